// File: rtl/if_fetch_queue_pkg.sv
// Shared defaults and the response-routing encoding for the instruction-fetch queue.
package if_fetch_queue_pkg;

   localparam int unsigned DEF_ADDRESS_LEN     = 32'd32;
   localparam int unsigned DEF_INSTRUCTION_LEN = 32'd32;
   localparam int unsigned DEF_QUEUE_DEPTH     = 32'd4;
   localparam int unsigned DEF_PC_STEP         = 32'd4;
   localparam int unsigned DEF_RESET_PC        = 32'd0;

   typedef enum logic [1:0] {
      RSP_NONE   = 2'd0,
      RSP_DROP   = 2'd1,
      RSP_QUEUE  = 2'd2,
      RSP_BYPASS = 2'd3
   } rsp_route_e;

   // Counters must be able to hold the value QUEUE_DEPTH itself.
   function automatic int unsigned ctr_width(input int unsigned depth);
      return $clog2(depth + 32'd1);
   endfunction

endpackage

// File: rtl/if_fetch_queue_fifo.sv
// fetch_fifo: synchronous FIFO with flush; the head word is readable without popping.
module fetch_fifo #(
   parameter int unsigned WIDTH = 32'd64,
   parameter int unsigned DEPTH = 32'd4,
   parameter int unsigned CW    = $clog2(DEPTH + 32'd1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [CW-1:0]    count
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push_s, do_pop_s;

   assign do_push_s = push & (count_q != CW'(DEPTH));
   assign do_pop_s  = pop & (count_q != {CW{1'b0}});

   // Pointer and occupancy next state; flush wins over push/pop.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = {PW{1'b0}};
         wr_ptr_d = {PW{1'b0}};
         count_d  = {CW{1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1'b1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1'b1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= {PW{1'b0}};
         wr_ptr_q <= {PW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are only observed while the entry is occupied.
   always_ff @(posedge clk) begin
      if (do_push_s && !flush) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch stage: PC generation, pipelined imem requests and a prefetch queue in front of ID.
// Define IF_QUEUE_BYPASS_EN to forward a response straight to ID while the queue is empty.
module if_fetch_queue
   import if_fetch_queue_pkg::*;
#(
   parameter int unsigned ADDRESS_LEN     = DEF_ADDRESS_LEN,
   parameter int unsigned INSTRUCTION_LEN = DEF_INSTRUCTION_LEN,
   parameter int unsigned QUEUE_DEPTH     = DEF_QUEUE_DEPTH,
   parameter int unsigned PC_STEP         = DEF_PC_STEP,
   parameter int unsigned RESET_PC        = DEF_RESET_PC
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       freeze,
   input  logic                       Branch_taken,
   input  logic [ADDRESS_LEN-1:0]     BranchAddr,
   output logic                       imem_req_valid,
   input  logic                       imem_req_ready,
   output logic [ADDRESS_LEN-1:0]     imem_addr,
   input  logic                       imem_rsp_valid,
   input  logic [INSTRUCTION_LEN-1:0] imem_rsp_data,
   output logic                       if_valid,
   output logic [ADDRESS_LEN-1:0]     PC,
   output logic [INSTRUCTION_LEN-1:0] Instruction
);

   localparam int unsigned CW = ctr_width(QUEUE_DEPTH);
   localparam int unsigned EW = ADDRESS_LEN + INSTRUCTION_LEN;
   localparam logic [ADDRESS_LEN-1:0] STEP     = ADDRESS_LEN'(PC_STEP);
   localparam logic [ADDRESS_LEN-1:0] START_PC = ADDRESS_LEN'(RESET_PC);
   localparam logic [CW:0]            CREDITS  = QUEUE_DEPTH[CW:0];

   logic [ADDRESS_LEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]          discard_q, discard_d;
   logic                   started_q, started_d;
   logic [CW-1:0]          q_count_s, inflight_s;
   logic [EW-1:0]          q_rdata_s;
   logic [ADDRESS_LEN-1:0] rsp_addr_s;
   logic                   req_fire_s, q_empty_s, q_pop_s, q_push_s, bypass_view_s;
   rsp_route_e             rsp_route_s;

   assign q_empty_s  = (q_count_s == {CW{1'b0}});
   assign q_pop_s    = ~q_empty_s & ~freeze;
   assign q_push_s   = (rsp_route_s == RSP_QUEUE);
   assign req_fire_s = imem_req_valid & imem_req_ready;
   assign imem_addr  = fetch_pc_q;
   // Occupied slots plus outstanding requests never exceed the queue depth.
   assign imem_req_valid = started_q & ~Branch_taken &
                           (({1'b0, q_count_s} + {1'b0, inflight_s}) < CREDITS);

`ifdef IF_QUEUE_BYPASS_EN
   assign bypass_view_s = q_empty_s & (discard_q == {CW{1'b0}}) & imem_rsp_valid & ~Branch_taken;
`else
   assign bypass_view_s = 1'b0;
`endif

   // Decide what happens to the response arriving this cycle.
   always_comb begin
      rsp_route_s = RSP_NONE;
      if (!imem_rsp_valid) begin
         rsp_route_s = RSP_NONE;
      end else if (Branch_taken || (discard_q != {CW{1'b0}})) begin
         rsp_route_s = RSP_DROP;
      end else if (bypass_view_s && !freeze) begin
         rsp_route_s = RSP_BYPASS;
      end else begin
         rsp_route_s = RSP_QUEUE;
      end
   end

   // Fetch PC and stale-response bookkeeping; a redirect overrides everything.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      discard_d  = discard_q;
      started_d  = 1'b1;
      if (Branch_taken) begin
         fetch_pc_d = BranchAddr;
         discard_d  = inflight_s - CW'(imem_rsp_valid);
      end else begin
         if (req_fire_s) begin
            fetch_pc_d = fetch_pc_q + STEP;
         end else begin
            fetch_pc_d = fetch_pc_q;
         end
         if (rsp_route_s == RSP_DROP) begin
            discard_d = discard_q - CW'(1'b1);
         end else begin
            discard_d = discard_q;
         end
      end
   end

   // Fetch-side state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_q <= START_PC;
         discard_q  <= {CW{1'b0}};
         started_q  <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         discard_q  <= discard_d;
         started_q  <= started_d;
      end
   end

   // Present the head entry (or the bypassed response) to ID.
   always_comb begin
      if_valid    = 1'b0;
      PC          = {ADDRESS_LEN{1'b0}};
      Instruction = {INSTRUCTION_LEN{1'b0}};
      if (bypass_view_s) begin
         if_valid    = 1'b1;
         PC          = rsp_addr_s + STEP;
         Instruction = imem_rsp_data;
      end else if (!q_empty_s) begin
         if_valid    = 1'b1;
         PC          = q_rdata_s[EW-1 -: ADDRESS_LEN] + STEP;
         Instruction = q_rdata_s[INSTRUCTION_LEN-1:0];
      end else begin
         if_valid    = 1'b0;
         PC          = {ADDRESS_LEN{1'b0}};
         Instruction = {INSTRUCTION_LEN{1'b0}};
      end
   end

   // Addresses of outstanding requests; its occupancy is the in-flight count.
   fetch_fifo #(
      .WIDTH (ADDRESS_LEN),
      .DEPTH (QUEUE_DEPTH),
      .CW    (CW)
   ) u_addr_fifo (
      .clk   (clk),
      .rst_n (rst),
      .push  (req_fire_s),
      .pop   (imem_rsp_valid),
      .flush (1'b0),
      .wdata (fetch_pc_q),
      .rdata (rsp_addr_s),
      .count (inflight_s)
   );

   fetch_fifo #(
      .WIDTH (EW),
      .DEPTH (QUEUE_DEPTH),
      .CW    (CW)
   ) u_prefetch_q (
      .clk   (clk),
      .rst_n (rst),
      .push  (q_push_s),
      .pop   (q_pop_s),
      .flush (Branch_taken),
      .wdata ({rsp_addr_s, imem_rsp_data}),
      .rdata (q_rdata_s),
      .count (q_count_s)
   );

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed scenarios plus random traffic against a request-level model.
module tb_if_fetch_queue;

   localparam int AL = 32;
   localparam int IL = 32;
   localparam int D  = 4;

   logic          clk = 1'b0, rst = 1'b0, freeze = 1'b0, Branch_taken = 1'b0;
   logic          imem_req_ready = 1'b0, imem_rsp_valid = 1'b0;
   logic [AL-1:0] BranchAddr = 32'h0;
   logic [IL-1:0] imem_rsp_data = 32'h0;
   logic          imem_req_valid, if_valid;
   logic [AL-1:0] imem_addr, PC;
   logic [IL-1:0] Instruction;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   if_fetch_queue dut (
      .clk(clk), .rst(rst), .freeze(freeze), .Branch_taken(Branch_taken), .BranchAddr(BranchAddr),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .if_valid(if_valid), .PC(PC), .Instruction(Instruction)
   );

   // Reference: fetch PC, buffered addresses, and outstanding requests tagged {stale, addr}.
   logic [AL-1:0] m_pc = 32'h0;
   bit            m_started = 1'b0;
   logic [AL-1:0] m_buf[$];
   logic [AL:0]   m_out[$];
   // Memory: in-order responses, each with its due cycle.
   logic [AL-1:0] mem_addr_q[$];
   longint        mem_due_q[$];
   longint        cyc = 0, last_due = 0;
   int            lat_min = 1, lat_max = 1;
   int            fires_seen = 0;
   logic          last_iv = 1'b0;
   logic [AL-1:0] last_pc = 32'h0, last_addr = 32'h0;

   function automatic logic [IL-1:0] mem_word(input logic [AL-1:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; Branch_taken = 1'b0; freeze = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
      #1;
      chk("rst_req_valid", {63'b0, imem_req_valid}, 64'd0);
      chk("rst_imem_addr", {32'b0, imem_addr}, 64'd0);
      chk("rst_if_valid", {63'b0, if_valid}, 64'd0);
      chk("rst_pc", {32'b0, PC}, 64'd0);
      chk("rst_instr", {32'b0, Instruction}, 64'd0);
      m_pc = 32'h0; m_started = 1'b0;
      m_buf.delete(); m_out.delete(); mem_addr_q.delete(); mem_due_q.delete();
      last_due = cyc;
      @(posedge clk); #2;
      rst = 1'b1;
   endtask

   // One clock: drive inputs, check outputs against the model, advance model at the edge.
   task automatic cycle(input bit br, input logic [AL-1:0] ba, input bit frz, input bit rdy);
      bit            rsp, exp_rv, exp_iv, byp;
      logic [AL-1:0] ra, hd;
      logic [AL:0]   o;
      longint        due;
      rsp = (mem_addr_q.size() > 0) && (mem_due_q[0] <= cyc);
      ra  = rsp ? mem_addr_q[0] : 32'h0;
      Branch_taken = br; BranchAddr = ba; freeze = frz; imem_req_ready = rdy;
      imem_rsp_valid = rsp; imem_rsp_data = rsp ? mem_word(ra) : $urandom;
      #2;
      exp_rv = m_started && !br && ((m_buf.size() + m_out.size()) < D);
      byp = 1'b0;
`ifdef IF_QUEUE_BYPASS_EN
      byp = rsp && !br && (m_buf.size() == 0) && (m_out.size() > 0) && !m_out[0][AL];
`endif
      exp_iv = (m_buf.size() > 0) || byp;
      chk("req_valid", {63'b0, imem_req_valid}, {63'b0, exp_rv});
      chk("imem_addr", {32'b0, imem_addr}, {32'b0, m_pc});
      chk("if_valid", {63'b0, if_valid}, {63'b0, exp_iv});
      if (exp_iv) begin
         hd = (m_buf.size() > 0) ? m_buf[0] : ra;
         chk("pc", {32'b0, PC}, {32'b0, hd + 32'd4});
         chk("instr", {32'b0, Instruction}, {32'b0, mem_word(hd)});
      end
      last_iv = if_valid; last_pc = PC; last_addr = imem_addr;
      if (imem_req_valid === 1'b1 && rdy) fires_seen++;
      @(posedge clk);
      if (br) begin
         m_buf.delete();
         if (rsp) o = m_out.pop_front();
         foreach (m_out[i]) m_out[i][AL] = 1'b1;
         m_pc = ba;
      end else begin
         if (exp_iv && !frz && (m_buf.size() > 0)) void'(m_buf.pop_front());
         if (rsp) begin
            o = m_out.pop_front();
            if (!o[AL] && !(byp && !frz)) m_buf.push_back(o[AL-1:0]);
         end
      end
      if (rsp) begin
         void'(mem_addr_q.pop_front());
         void'(mem_due_q.pop_front());
      end
      if (exp_rv && rdy) begin
         due = cyc + longint'($urandom_range(lat_max, lat_min));
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         mem_addr_q.push_back(m_pc); mem_due_q.push_back(due);
         m_out.push_back({1'b0, m_pc});
         m_pc = m_pc + 32'd4;
      end
      m_started = 1'b1;
      cyc++;
      #1;
   endtask

   initial begin
      logic [AL-1:0] r;
      do_reset();

      // Back-to-back issue with a fast memory.
      lat_min = 1; lat_max = 1; fires_seen = 0;
      for (int n = 0; n < 5; n++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
      chk("fast_fires", 64'(fires_seen), 64'd4);
      for (int n = 0; n < 8; n++) cycle(1'b0, 32'h0, 1'b0, 1'b1);

      // Reset while busy, then latency 3 with ID frozen.
      do_reset();
      lat_min = 3; lat_max = 3; fires_seen = 0;
      for (int n = 0; n < 10; n++) cycle(1'b0, 32'h0, 1'b1, 1'b1);
      chk("freeze_fires", 64'(fires_seen), 64'd4);
      for (int n = 0; n < 8; n++) cycle(1'b0, 32'h0, 1'b0, 1'b1);

      // Redirect with three requests in flight.
      for (int n = 0; n < 30 && m_out.size() != 3; n++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
      cycle(1'b1, 32'h100, 1'b0, 1'b1);
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      chk("branch_addr", {32'b0, last_addr}, 64'h100);
      for (int n = 0; n < 30 && !last_iv; n++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
      chk("branch_first_pc", {32'b0, last_pc}, 64'h104);

      // Redirect coinciding with a response while frozen.
      lat_min = 2; lat_max = 2;
      for (int n = 0; n < 30 && !(mem_addr_q.size() > 0 && mem_due_q[0] == cyc); n++)
         cycle(1'b0, 32'h0, 1'b0, 1'b1);
      cycle(1'b1, 32'h200, 1'b1, 1'b1);
      cycle(1'b0, 32'h0, 1'b1, 1'b1);
      chk("br_rsp_if_valid", {63'b0, last_iv}, 64'd0);
      for (int n = 0; n < 6; n++) cycle(1'b0, 32'h0, 1'b0, 1'b1);

      // Fetch PC wraps at the top of the address space.
      cycle(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
      for (int n = 0; n < 30 && m_pc == 32'hFFFF_FFFC; n++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      chk("wrap_addr", {32'b0, last_addr}, 64'h0);

      // Random traffic.
      lat_min = 1; lat_max = 4;
      for (int n = 0; n < 600; n++) begin
         if (n == 300) do_reset();
         r = $urandom; r[1:0] = 2'b00;
         cycle(($urandom_range(99, 0) < 5), r, ($urandom_range(99, 0) < 30),
               ($urandom_range(99, 0) < 75));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised instruction-fetch stage: it generates the fetch PC, issues pipelined requests to a variable-latency instruction memory, and buffers returned instructions in a prefetch queue in front of ID. It generalises the single-cycle fetch stage with configurable queue depth, multiple outstanding requests, stale-response discard on branch redirect, and freeze-tolerant buffering. It sits between the instruction memory port and the IF/ID pipeline register.

## Interface
- ADDRESS_LEN, 32: PC/address width
- INSTRUCTION_LEN, 32: instruction width
- QUEUE_DEPTH, 4: prefetch entries (power of two, ≥2); also the max requests in flight
- PC_STEP, 4: PC increment per instruction
- RESET_PC, 0: first fetch address

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- freeze  in  1  ID stall; head entry is held, not consumed
- Branch_taken  in  1  redirect request from EXE
- BranchAddr  in  ADDRESS_LEN  redirect target
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  ADDRESS_LEN  fetch address
- imem_rsp_valid  in  1  in-order response valid (no back-pressure)
- imem_rsp_data  in  INSTRUCTION_LEN  fetched instruction
- if_valid  out  1  Instruction/PC valid
- PC  out  ADDRESS_LEN  address of head instruction + PC_STEP
- Instruction  out  INSTRUCTION_LEN  head instruction

## Operation
- State: fetch_pc, queue (data + address per entry), rd/wr pointers, count, inflight counter, discard counter. Counters are $clog2(QUEUE_DEPTH+1) bits.
- Request issue: imem_req_valid = ~Branch_taken & (count + inflight < QUEUE_DEPTH); imem_addr = fetch_pc. On fire (valid & ready): fetch_pc += PC_STEP (wraps modulo 2^ADDRESS_LEN), inflight++.
- Credit rule guarantees a queue slot for every in-flight response; responses are never refused.
- Response: inflight--. If discard > 0: drop data, discard--. Else write {data, address} to queue tail. The address of each entry is tracked via a parallel address FIFO written on request fire.
- Consume: if_valid & ~freeze pops head.
- Redirect (Branch_taken=1), has priority over freeze and everything else: queue flushed (count=0), fetch_pc=BranchAddr, discard = inflight minus any response arriving this cycle; the arriving response is dropped. No request issued that cycle.
- Simultaneous push and pop: count unchanged.

## Timing
- Reset values: imem_req_valid=0, imem_addr=RESET_PC, if_valid=0, PC=0, Instruction=0, all counters 0, fetch_pc=RESET_PC.
- First request: first clk edge after rst rises, imem_req_valid=1, imem_addr=RESET_PC.
- Response in cycle N visible at output in N+1 (queue latency 1), unless bypass is enabled.
- Branch in cycle N: cycle N+1 imem_addr=BranchAddr, if_valid=0 until first non-stale response is queued.
- Full queue: imem_req_valid=0; resumes in the cycle after a pop frees credit.
- Reset mid-operation: all state cleared immediately (asynchronous); responses in flight at reset are the memory's responsibility to cancel.

## Configuration
- IF_QUEUE_BYPASS_EN defined: when queue empty, discard=0 and a response arrives, it drives Instruction/PC with if_valid=1 combinationally the same cycle; if ~freeze it is consumed without being written. Undefined: responses always written, first visible next cycle.

## Structure
- Shared package/Defines: ADDRESS_LEN, INSTRUCTION_LEN defaults, PC_STEP, RESET_PC.
- One sub-module: fetch_fifo (parametrised sync FIFO, width ADDRESS_LEN+INSTRUCTION_LEN, depth QUEUE_DEPTH, push/pop/flush, count out).

## Test plan
- Reset release, zero-latency memory, freeze=0 -> addrs 0,4,8,12 issued back-to-back; PC 4,8,12 with matching instructions, one per cycle.
- Memory latency 3, freeze held 10 cycles -> exactly 4 requests issued, then req_valid=0; on release 4 instructions in order, no loss.
- Branch_taken with 3 in flight, BranchAddr=0x100 -> next imem_addr=0x100; 3 stale responses dropped; first output PC=0x104.
- Branch and response same cycle with freeze=1 -> response dropped, discard=inflight-1, queue empty next cycle.
- fetch_pc=0xFFFFFFFC -> next request address 0x0.
- With IF_QUEUE_BYPASS_EN, empty queue, response arrives -> if_valid=1 same cycle; without, next cycle.
